pc_select_predict: RTL

Parametrised fetch-stage PC unit for the pipelined Y86-64 core, succeeding the single-cycle SEQ PC update. It holds the predicted-PC register and selects the fetch PC each cycle, choosing between the prediction, a mispredicted-branch correction from M and a return target from W. Branch direction comes from a selectable predictor: always-taken, BTFN, or a table of 2-bit saturating counters trained from M. It also exports the prediction bit for the pipeline and a saturating mispredict counter.

---
 rtl/pc_select_predict.sv | 63 ++++++
 1 files changed

// File: rtl/pc_select_predict.sv
// pc_select_predict: fetch PC select with predicted-PC register, selectable branch predictor and mispredict counter
module pc_select_predict #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                PRED_MODE = 2,
  parameter int                BHT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_stall,
  input  logic [3:0]        f_icode,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  input  logic              m_jxx_valid,
  input  logic              m_cnd,
  input  logic              m_pred_taken,
  input  logic [ADDR_W-1:0] m_pc,
  input  logic [ADDR_W-1:0] m_valC,
  input  logic [ADDR_W-1:0] m_valP,
  input  logic [3:0]        w_icode,
  input  logic [ADDR_W-1:0] w_valM,
  output logic [ADDR_W-1:0] f_pc,
  output logic              f_pred_taken,
  output logic              redirect,
  output logic [15:0]       mispredict_cnt
);
  localparam int IDX = $clog2(BHT_DEPTH);
  localparam logic [3:0] JXX = 4'h7;
  localparam logic [3:0] CALL = 4'h8;
  localparam logic [3:0] RET = 4'h9;
  logic [ADDR_W-1:0] pred_pc_q, pred_pc_d;
  logic [1:0]        bht_q [BHT_DEPTH];
  logic [1:0]        bht_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [IDX-1:0]    m_idx;
  logic              mispredict, dir;
  logic              unused_bits;
  assign m_idx = m_pc[IDX-1:0];
  assign unused_bits = ^m_pc[ADDR_W-1:IDX];
  assign mispredict = m_jxx_valid && (m_cnd != m_pred_taken);
  assign mispredict_cnt = cnt_q;
  always_comb begin
    f_pc = mispredict ? (m_cnd ? m_valC : m_valP) : (w_icode == RET ? w_valM : pred_pc_q);
    redirect = mispredict || (w_icode == RET);
    dir = PRED_MODE == 0 ? 1'b1 : PRED_MODE == 1 ? (f_valC < f_valP) : bht_q[f_pc[IDX-1:0]][1];
    f_pred_taken = (f_icode == JXX) && dir;
    pred_pc_d = f_stall ? pred_pc_q : ((f_icode == CALL) || f_pred_taken) ? f_valC : f_valP;
    cnt_d = (mispredict && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    bht_d = m_cnd ? (bht_q[m_idx] == 2'd3 ? 2'd3 : bht_q[m_idx] + 2'd1)
                  : (bht_q[m_idx] == 2'd0 ? 2'd0 : bht_q[m_idx] - 2'd1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_pc_q <= RESET_PC;
      cnt_q <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b10;
    end else begin
      pred_pc_q <= pred_pc_d;
      cnt_q <= cnt_d;
      if (PRED_MODE == 2 && m_jxx_valid) bht_q[m_idx] <= bht_d;
    end
  end
endmodule
